// File: rtl/poly_horner_engine.sv
// poly_horner_engine: FIFO-fed Horner polynomial evaluator with overflow detection and saturate/wrap
module poly_horner_engine #(
  parameter int WIDTH      = 16,
  parameter int DEG_W      = 4,
  parameter int MAX_DEGREE = 7,
  parameter int SATURATE   = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   empty_instruction,
  input  logic [DEG_W+WIDTH-1:0] instruction,
  output logic                   read_enable_instruction,
  input  logic                   empty_data,
  input  logic [WIDTH-1:0]       data,
  output logic                   read_enable_data,
  input  logic                   full_result,
  output logic [WIDTH-1:0]       result,
  output logic                   write_enable_result,
  input  logic                   full_status,
  output logic [1:0]             status,
  output logic                   write_enable_status,
  output logic                   busy
);
  typedef enum logic [1:0] {IDLE, ACCUM, WRITE} state_t;
  localparam logic [WIDTH-1:0] MAX_V = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [DEG_W-1:0] MAX_D = DEG_W'(MAX_DEGREE);
  state_t state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d, x_q, x_d, result_q, result_d, acc_n;
  logic [DEG_W-1:0] count_q, count_d;
  logic [1:0] status_q, status_d;
  logic ovf_q, ovf_d, err_q, err_d, ovf_n, t_ovf;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH:0] t;
  always_comb begin
    prod = {{WIDTH{acc_q[WIDTH-1]}}, acc_q} * {{WIDTH{x_q[WIDTH-1]}}, x_q};
    t = {prod[2*WIDTH-1], prod} + {{(WIDTH+1){data[WIDTH-1]}}, data};
    // t fits in WIDTH signed bits only when its upper bits are a pure sign extension
    t_ovf = !(&t[2*WIDTH:WIDTH-1] || !(|t[2*WIDTH:WIDTH-1]));
    acc_n = err_q ? acc_q : !t_ovf ? t[WIDTH-1:0] : (SATURATE != 0) ? (t[2*WIDTH] ? MIN_V : MAX_V) : t[WIDTH-1:0];
    ovf_n = !err_q && (ovf_q || t_ovf);
    read_enable_instruction = reset && state_q == IDLE && !empty_instruction;
    read_enable_data = reset && state_q == ACCUM && !empty_data;
    write_enable_result = reset && state_q == WRITE && !full_result && !full_status;
    write_enable_status = write_enable_result;
    busy = state_q != IDLE;
    result = result_q;
    status = status_q;
    state_d = state_q;
    acc_d = acc_q;
    x_d = x_q;
    count_d = count_q;
    ovf_d = ovf_q;
    err_d = err_q;
    result_d = result_q;
    status_d = status_q;
    if (read_enable_instruction) begin
      x_d = instruction[WIDTH-1:0];
      count_d = instruction[DEG_W+WIDTH-1:WIDTH];
      acc_d = '0;
      ovf_d = 1'b0;
      err_d = instruction[DEG_W+WIDTH-1:WIDTH] > MAX_D;
      state_d = ACCUM;
    end
    if (read_enable_data) begin
      acc_d = acc_n;
      ovf_d = ovf_n;
      count_d = (count_q == '0) ? count_q : count_q - 1'b1;
      state_d = (count_q == '0) ? WRITE : ACCUM;
      result_d = (count_q == '0) ? (err_q ? '0 : acc_n) : result_q;
      status_d = (count_q == '0) ? {err_q, ovf_n} : status_q;
    end
    if (write_enable_result) state_d = IDLE;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      acc_q <= '0;
      x_q <= '0;
      count_q <= '0;
      ovf_q <= 1'b0;
      err_q <= 1'b0;
      result_q <= '0;
      status_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      x_q <= x_d;
      count_q <= count_d;
      ovf_q <= ovf_d;
      err_q <= err_d;
      result_q <= result_d;
      status_q <= status_d;
    end
  end
endmodule

// File: tb/tb_poly_horner_engine.sv
// tb_poly_horner_engine: scoreboard bench driving saturating and wrapping instances from shared FIFO models
module tb_poly_horner_engine;
  typedef struct {
    logic [15:0] rs, rw;
    logic [1:0]  ss, sw;
    int          lat, d;
  } exp_t;
  logic clock = 0, reset = 0;
  logic empty_instruction = 1, empty_data = 1, full_result = 0, full_status = 0;
  logic [19:0] instruction = '0;
  logic [15:0] data = '0;
  logic rei0, red0, wer0, wes0, busy0, rei1, red1, wer1, wes1, busy1;
  logic [15:0] res0, res1;
  logic [1:0] st0, st1;
  logic [19:0] iq[$];
  logic [15:0] dq[$];
  exp_t sb[$];
  int cf[16];
  int errors = 0, checks = 0, cyc = 0, ip_cyc = 0, npop = 0;
  bit rst_req = 1, stall_d = 0, stall_full = 0, pi = 0, pd = 0;
  event tick;
  always #5 clock = ~clock;
  poly_horner_engine #(.WIDTH(16), .DEG_W(4), .MAX_DEGREE(7), .SATURATE(1)) dut_sat (
    .clock(clock), .reset(reset), .empty_instruction(empty_instruction), .instruction(instruction),
    .read_enable_instruction(rei0), .empty_data(empty_data), .data(data), .read_enable_data(red0),
    .full_result(full_result), .result(res0), .write_enable_result(wer0), .full_status(full_status),
    .status(st0), .write_enable_status(wes0), .busy(busy0));
  poly_horner_engine #(.WIDTH(16), .DEG_W(4), .MAX_DEGREE(7), .SATURATE(0)) dut_wrap (
    .clock(clock), .reset(reset), .empty_instruction(empty_instruction), .instruction(instruction),
    .read_enable_instruction(rei1), .empty_data(empty_data), .data(data), .read_enable_data(red1),
    .full_result(full_result), .result(res1), .write_enable_result(wer1), .full_status(full_status),
    .status(st1), .write_enable_status(wes1), .busy(busy1));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic longint wrap16(input longint v);
    longint w = v & 64'hFFFF;
    return w >= 32768 ? w - 65536 : w;
  endfunction
  function automatic bit out16(input longint v);
    return v > 32767 || v < -32768;
  endfunction
  task automatic enq(input int d, input int x, input int lat);
    longint as = 0, aw = 0, t;
    bit os = 0, ow = 0;
    exp_t e;
    for (int i = 0; i <= d; i++) begin
      dq.push_back(16'(cf[i]));
      t = as * x + cf[i];
      os |= out16(t);
      as = t > 32767 ? 32767 : t < -32768 ? -32768 : t;
      t = aw * x + cf[i];
      ow |= out16(t);
      aw = wrap16(t);
    end
    iq.push_back({4'(d), 16'(x)});
    e.d = d;
    e.lat = lat;
    e.rs = d > 7 ? 16'h0 : 16'(as);
    e.rw = d > 7 ? 16'h0 : 16'(aw);
    e.ss = d > 7 ? 2'b10 : {1'b0, os};
    e.sw = d > 7 ? 2'b10 : {1'b0, ow};
    sb.push_back(e);
  endtask
  task automatic settle(input int lim);
    int n = 0;
    while ((sb.size() != 0 || iq.size() != 0 || busy0) && n < lim) begin
      @(tick);
      n++;
    end
    if (sb.size() != 0 || iq.size() != 0 || busy0) chk("timeout_idle", 0, 1);
  endtask
  task automatic wait_pop(input bit data_pop, input int lim);
    int n = 0;
    do begin
      @(tick);
      n++;
    end while (!(data_pop ? pd : pi) && n < lim);
    if (!(data_pop ? pd : pi)) chk("timeout_pop", 0, 1);
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      reset = !rst_req;
      empty_instruction = iq.size() == 0;
      instruction = iq.size() != 0 ? iq[0] : '0;
      empty_data = dq.size() == 0 || stall_d;
      data = dq.size() != 0 ? dq[0] : '0;
      full_result = 1'b0;
      full_status = stall_full;
      #1;
      cyc++;
      pi = rei0;
      pd = red0;
      if (pi) begin
        ip_cyc = cyc;
        npop = 0;
      end
      if (pd) npop++;
      if (wer0 || wes0) begin
        if (sb.size() == 0) chk("spurious_push", 1, 0);
        else begin
          e = sb.pop_front();
          chk("res_sat", res0, e.rs);
          chk("st_sat", st0, e.ss);
          chk("res_wrap", res1, e.rw);
          chk("st_wrap", st1, e.sw);
          chk("we_pair", {wer0, wes0, wer1, wes1}, 4'hF);
          chk("data_pops", npop, e.d + 1);
          if (e.lat >= 0) chk("latency", cyc - ip_cyc, e.lat);
        end
      end
      ->tick;
      @(posedge clock);
      #1;
      if (pi && iq.size() != 0) void'(iq.pop_front());
      if (pd && dq.size() != 0) void'(dq.pop_front());
    end
  end
  initial begin
    int d, x;
    repeat (3) @(tick);
    chk("rst_busy", busy0, 0);
    chk("rst_res", res0, 0);
    chk("rst_st", st0, 0);
    chk("rst_en", {rei0, red0, wer0, wes0}, 0);
    rst_req = 0;
    @(tick);
    cf[0] = 3; cf[1] = 4; cf[2] = 5;
    enq(2, 2, 4);
    settle(50);
    cf[0] = 2; cf[1] = 7;
    enq(1, -3, 3);
    cf[0] = -4;
    enq(0, 9, 2);
    settle(50);
    cf[0] = 1; cf[1] = 0; cf[2] = 0;
    enq(2, 300, 4);
    cf[0] = 1; cf[1] = 1;
    enq(1, 1, 3);
    settle(50);
    for (int i = 0; i < 10; i++) cf[i] = i + 1;
    enq(9, 5, 11);
    cf[0] = 42;
    enq(0, 0, 2);
    settle(80);
    cf[0] = 1; cf[1] = 2; cf[2] = 3; cf[3] = 4;
    enq(3, 3, -1);
    wait_pop(0, 20);
    wait_pop(1, 20);
    stall_d = 1;
    repeat (3) begin
      @(tick);
      chk("stall_red", red0, 0);
    end
    stall_d = 0;
    settle(50);
    stall_full = 1;
    cf[0] = 5; cf[1] = 6;
    enq(1, -2, -1);
    for (int n = 0; n < 30 && !(busy0 && dq.size() == 0); n++) @(tick);
    repeat (2) begin
      @(tick);
      chk("full_we", {wer0, wes0}, 0);
      chk("full_hold", res0, sb.size() != 0 ? sb[0].rs : 16'hDEAD);
    end
    stall_full = 0;
    settle(50);
    cf[0] = 3; cf[1] = 4; cf[2] = 5;
    enq(2, 2, -1);
    wait_pop(0, 20);
    wait_pop(1, 20);
    rst_req = 1;
    @(tick);
    chk("abort_busy", {busy0, busy1}, 0);
    chk("abort_res", res0, 0);
    chk("abort_st", st0, 0);
    chk("abort_en", {rei0, red0, wer0, wes0, rei1, red1, wer1, wes1}, 0);
    iq.delete();
    dq.delete();
    sb.delete();
    rst_req = 0;
    @(tick);
    cf[0] = 2; cf[1] = 3;
    enq(1, 4, 3);
    settle(50);
    for (int k = 0; k < 8; k++) begin
      d = int'($urandom_range(0, 7));
      x = int'($urandom_range(0, 600)) - 300;
      for (int i = 0; i <= d; i++) cf[i] = int'($urandom_range(0, 2000)) - 1000;
      enq(d, x, d + 2);
    end
    settle(400);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/poly_horner_engine.md
Name: poly_horner_engine

Overview:
Parametrised next-generation polynomial evaluation core. It pops an instruction carrying x and a degree d, then streams d+1 signed coefficients (highest order first) and evaluates them by Horner's rule. It pushes one result word and one status word per instruction. It sits between the instruction/data source FIFOs and the result/status sink FIFOs, and adds variable degree, configurable width, overflow detection and a saturate/wrap mode.

Parameters:
WIDTH, 16, signed two's-complement width of x, coefficients and result
DEG_W, 4, width of the degree field in an instruction
MAX_DEGREE, 7, largest legal degree; must be <= 2**DEG_W-1
SATURATE, 1, 1 = clip to signed WIDTH range on overflow, 0 = wrap (keep low WIDTH bits)

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
empty_instruction  in  1  instruction FIFO empty
instruction  in  DEG_W+WIDTH  {degree[DEG_W+WIDTH-1:WIDTH], x[WIDTH-1:0]}, first-word-fall-through
read_enable_instruction  out  1  pop instruction FIFO
empty_data  in  1  coefficient FIFO empty
data  in  WIDTH  signed coefficient, first-word-fall-through
read_enable_data  out  1  pop coefficient FIFO
full_result  in  1  result FIFO full
result  out  WIDTH  evaluated value
write_enable_result  out  1  push result
full_status  in  1  status FIFO full
status  out  2  {degree_error, overflow}
write_enable_status  out  1  push status
busy  out  1  high outside IDLE

Behaviour:
- Reset is asynchronous and active-low. While reset=0: state IDLE; acc, result, status, count and latched x/degree all 0; busy=0; all enables 0.
- Enables are combinational from the state and FIFO flags. result and status are registered.
- IDLE:
  - read_enable_instruction = !empty_instruction.
  - On a pop, the core latches x and degree, sets count=degree, acc=0, ovf=0, err=(degree>MAX_DEGREE), then goes to ACCUM.
- ACCUM:
  - read_enable_data = !empty_data. At most one coefficient is consumed per cycle.
  - The core stalls with no pop while empty_data=1.
  - On a pop, the core computes t = acc*x + sign_extend(data) at 2*WIDTH+1 bits.
    - If t is outside [-2**(WIDTH-1), 2**(WIDTH-1)-1], ovf is set. ovf stays set until the next instruction.
    - acc = clip(t) if SATURATE=1, else t[WIDTH-1:0].
  - If count==0 on this pop, the next state is WRITE. Otherwise count decrements.
- WRITE:
  - result = err ? 0 : acc; status = {err, err ? 0 : ovf}. Both are registered on entry and held stable.
  - write_enable_result = write_enable_status = !full_result && !full_status. Both push in the same cycle, never one without the other.
  - After the push the core returns to IDLE.
- Degree error (degree>MAX_DEGREE): the core still drains exactly degree+1 coefficients to keep the streams aligned. It performs no arithmetic side effects, then writes result 0 with status 2'b10.
- degree=0: one coefficient is consumed and result = that coefficient (no multiply overflow possible).
- Latency with no stalls:
  - instruction pop at cycle 0;
  - coefficient pops at cycles 1..d+1;
  - push at cycle d+2;
  - IDLE at cycle d+3.
  - Throughput is one evaluation per d+3 cycles.
- Reset asserted mid-operation aborts the evaluation. No write occurs; partial FIFO consumption is not undone.
- If empty is raised in the same cycle as a pop attempt, there is no pop and no state change.

Test Plan:
- WIDTH=16, SATURATE=1, instruction {d=2, x=2}, data 3,4,5, no stalls -> single push at cycle 4: result=25, status=00. read_enable_data high at cycles 1-3.
- {d=1, x=-3}, data 2,7 -> result=1, status=00. Then {d=0, x=9}, data -4 -> result=-4, status=00, pushed in back-to-back evaluations with the IDLE cycle between.
- {d=2, x=300}, data 1,0,0: with SATURATE=1 -> result=32767, status=01. With SATURATE=0 -> result=24464, status=01. Next instruction {d=1, x=1}, data 1,1 -> status=00 (ovf cleared).
- {d=9, x=5} with MAX_DEGREE=7, data of ten words 1..10 followed by {d=0, x=0}, data 42 -> first push result=0, status=10 after exactly 10 data pops. Second push result=42, status=00.
- Stalls: empty_data high for 3 cycles mid-ACCUM -> no read_enable_data and acc unchanged during the stall. full_status high for 2 cycles in WRITE -> neither write enable asserts, result held. The correct value pushes once when the FIFO frees.
- Reset (reset=0) during ACCUM after 1 of 3 coefficients -> busy=0, result=0, status=0, no write enables. After release, a new instruction evaluates correctly.
